// File: rtl/tm1637_receiver.sv
// TM1637 bus receiver: oversamples the two-wire CLK/DIO bus on clk, detects
// start/stop conditions, shifts bytes in LSB-first and optionally ACKs them.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | bus idle or unknown; waiting for a start condition
// START  | start seen; waiting for the first CLK fall
// SHIFT  | sampling data bits on CLK rises (8 per byte)
// ACK    | pulling DIO low from the 8th CLK fall to the 9th CLK fall
// HOLD   | listen-only: skipping the 9th clock without driving DIO
module tm1637_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter bit ACK_ENABLE  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bus_clk,
  input  logic       bus_dio,
  output logic       dio_oe,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       first_byte,
  output logic       frame_start,
  output logic       frame_end,
  output logic       frame_error
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SHIFT,
    ST_ACK,
    ST_HOLD
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] dio_sync_q, dio_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   sdio_prev_q, sdio_prev_d;
  logic [7:0]             shreg_q, shreg_d;
  logic [2:0]             cnt_q, cnt_d;
  logic                   byte_done_q, byte_done_d;
  logic                   rise_pend_q, rise_pend_d;
  logic                   first_pend_q, first_pend_d;
  logic [7:0]             data_q, data_d;
  logic                   data_valid_q, data_valid_d;
  logic                   first_byte_q, first_byte_d;
  logic                   frame_start_q, frame_start_d;
  logic                   frame_end_q, frame_end_d;
  logic                   frame_error_q, frame_error_d;
  logic                   dio_oe_q, dio_oe_d;
  logic                   oe_dly_q, oe_dly_d;

  logic sclk, sdio;
  logic sclk_rise, sclk_fall;
  logic det_en, start_det, stop_det;
  logic partial;

  // Bus condition decode from the synchronized lines only.
  always_comb begin
    sclk      = clk_sync_q[SYNC_STAGES-1];
    sdio      = dio_sync_q[SYNC_STAGES-1];
    sclk_rise = sclk & ~sclk_prev_q;
    sclk_fall = ~sclk & sclk_prev_q;
    // Our own ACK drive and its release must never look like start/stop.
    det_en    = ~dio_oe_q & ~oe_dly_q;
    // sclk must be steady high, so a simultaneous CLK/DIO change never counts.
    start_det = det_en & sclk & sclk_prev_q & sdio_prev_q & ~sdio;
    stop_det  = det_en & sclk & sclk_prev_q & ~sdio_prev_q & sdio;
    // A bit is complete only once its clock has fallen: the CLK rise that
    // sets up a start/stop is counted in cnt_q but is not a data bit.
    partial   = ~byte_done_q & (cnt_q > {2'b00, rise_pend_q});
  end

  // Next-state logic for the synchronizers, FSM and registered outputs.
  always_comb begin
    clk_sync_d    = {clk_sync_q[SYNC_STAGES-2:0], bus_clk};
    dio_sync_d    = {dio_sync_q[SYNC_STAGES-2:0], bus_dio};
    sclk_prev_d   = sclk;
    sdio_prev_d   = sdio;
    state_d       = state_q;
    shreg_d       = shreg_q;
    cnt_d         = cnt_q;
    byte_done_d   = byte_done_q;
    rise_pend_d   = rise_pend_q;
    first_pend_d  = first_pend_q;
    data_d        = data_q;
    data_valid_d  = 1'b0;
    first_byte_d  = first_byte_q;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    frame_error_d = 1'b0;
    dio_oe_d      = dio_oe_q;
    oe_dly_d      = dio_oe_q;

    if (state_q == ST_IDLE) begin
      if (start_det) begin
        state_d       = ST_START;
        frame_start_d = 1'b1;
        first_pend_d  = 1'b1;
        cnt_d         = 3'd0;
        byte_done_d   = 1'b0;
        rise_pend_d   = 1'b0;
      end
    end else if (start_det) begin
      state_d       = ST_START;
      frame_start_d = 1'b1;
      frame_error_d = partial;
      first_pend_d  = 1'b1;
      cnt_d         = 3'd0;
      byte_done_d   = 1'b0;
      rise_pend_d   = 1'b0;
      dio_oe_d      = 1'b0;
    end else if (stop_det) begin
      state_d       = ST_IDLE;
      frame_end_d   = 1'b1;
      frame_error_d = partial;
      cnt_d         = 3'd0;
      byte_done_d   = 1'b0;
      rise_pend_d   = 1'b0;
      dio_oe_d      = 1'b0;
    end else begin
      case (state_q)
        ST_START: begin
          if (sclk_fall) begin
            state_d     = ST_SHIFT;
            cnt_d       = 3'd0;
            byte_done_d = 1'b0;
            rise_pend_d = 1'b0;
          end
        end
        ST_SHIFT: begin
          if (sclk_rise && !byte_done_q) begin
            shreg_d[cnt_q] = sdio;
            cnt_d          = cnt_q + 3'd1;
            rise_pend_d    = 1'b1;
            if (cnt_q == 3'd7) begin
              data_d       = {sdio, shreg_q[6:0]};
              data_valid_d = 1'b1;
              first_byte_d = first_pend_q;
              first_pend_d = 1'b0;
              byte_done_d  = 1'b1;
            end
          end else if (sclk_fall) begin
            rise_pend_d = 1'b0;
            if (byte_done_q) begin
              byte_done_d = 1'b0;
              state_d     = ACK_ENABLE ? ST_ACK : ST_HOLD;
              dio_oe_d    = ACK_ENABLE;
            end
          end
        end
        ST_ACK: begin
          if (sclk_fall) begin
            state_d  = ST_SHIFT;
            cnt_d    = 3'd0;
            dio_oe_d = 1'b0;
          end
        end
        ST_HOLD: begin
          if (sclk_fall) begin
            state_d = ST_SHIFT;
            cnt_d   = 3'd0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers; synchronizers reset to the idle-high bus.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync_q    <= '1;
      dio_sync_q    <= '1;
      sclk_prev_q   <= 1'b1;
      sdio_prev_q   <= 1'b1;
      state_q       <= ST_IDLE;
      shreg_q       <= 8'h00;
      cnt_q         <= 3'd0;
      byte_done_q   <= 1'b0;
      rise_pend_q   <= 1'b0;
      first_pend_q  <= 1'b0;
      data_q        <= 8'h00;
      data_valid_q  <= 1'b0;
      first_byte_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      frame_error_q <= 1'b0;
      dio_oe_q      <= 1'b0;
      oe_dly_q      <= 1'b0;
    end else begin
      clk_sync_q    <= clk_sync_d;
      dio_sync_q    <= dio_sync_d;
      sclk_prev_q   <= sclk_prev_d;
      sdio_prev_q   <= sdio_prev_d;
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      cnt_q         <= cnt_d;
      byte_done_q   <= byte_done_d;
      rise_pend_q   <= rise_pend_d;
      first_pend_q  <= first_pend_d;
      data_q        <= data_d;
      data_valid_q  <= data_valid_d;
      first_byte_q  <= first_byte_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      frame_error_q <= frame_error_d;
      dio_oe_q      <= dio_oe_d;
      oe_dly_q      <= oe_dly_d;
    end
  end

  assign dio_oe      = dio_oe_q;
  assign data        = data_q;
  assign data_valid  = data_valid_q;
  assign first_byte  = first_byte_q;
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_tm1637_receiver.sv
// Bench for tm1637_receiver: a bus master drives two instances (ACK on with
// 2 sync stages, listen-only with 3 sync stages) from the same CLK/DIO
// traffic; a protocol-level model predicts frame events and received bytes.
module tb_tm1637_receiver;
  localparam int HALF = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       m_clk, m_dio;
  logic       dio_w [2];
  logic       oe    [2];
  logic [7:0] dat   [2];
  logic       dv    [2];
  logic       fb    [2];
  logic       fs    [2];
  logic       fe    [2];
  logic       ferr  [2];

  // Open-drain wire per instance: low if the master or the receiver pulls it.
  assign dio_w[0] = m_dio & ~oe[0];
  assign dio_w[1] = m_dio & ~oe[1];

  tm1637_receiver #(.SYNC_STAGES(2), .ACK_ENABLE(1'b1)) u_ack (
    .clk(clk), .reset(reset), .bus_clk(m_clk), .bus_dio(dio_w[0]),
    .dio_oe(oe[0]), .data(dat[0]), .data_valid(dv[0]), .first_byte(fb[0]),
    .frame_start(fs[0]), .frame_end(fe[0]), .frame_error(ferr[0]));

  tm1637_receiver #(.SYNC_STAGES(3), .ACK_ENABLE(1'b0)) u_lo (
    .clk(clk), .reset(reset), .bus_clk(m_clk), .bus_dio(dio_w[1]),
    .dio_oe(oe[1]), .data(dat[1]), .data_valid(dv[1]), .first_byte(fb[1]),
    .frame_start(fs[1]), .frame_end(fe[1]), .frame_error(ferr[1]));

  int checks = 0;
  int errors = 0;

  // Reference model: protocol-level view of what the master has sent.
  int         exp_fs = 0, exp_fe = 0, exp_err = 0;
  logic [8:0] exp_q[$];
  logic [7:0] last_data = 8'h00;
  bit         in_frame = 0, first = 0;
  int         bits = 0;

  // Observed events.
  int         n_fs[2], n_fe[2], n_err[2], n_err_alone[2];
  logic [8:0] got0[$], got1[$];
  bit         oe1_seen = 0;

  initial begin
    for (int k = 0; k < 2; k++) begin
      n_fs[k] = 0; n_fe[k] = 0; n_err[k] = 0; n_err_alone[k] = 0;
    end
  end

  always @(negedge clk) begin
    if (dv[0]) got0.push_back({fb[0], dat[0]});
    if (dv[1]) got1.push_back({fb[1], dat[1]});
    for (int k = 0; k < 2; k++) begin
      if (fs[k]) n_fs[k]++;
      if (fe[k]) n_fe[k]++;
      if (ferr[k]) begin
        if (fs[k] || fe[k]) n_err[k]++;
        else n_err_alone[k]++;
      end
    end
    if (oe[1]) oe1_seen = 1;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: observed no finish, expected finish before 2ms");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wt();
    repeat (HALF) @(posedge clk);
    #2;
  endtask

  task automatic bus_bit(input logic b);
    m_dio = b; wt();
    m_clk = 1'b1; wt();
    m_clk = 1'b0; wt();
  endtask

  task automatic bus_start();
    if (m_clk == 1'b0) begin
      m_dio = 1'b1; wt();
      m_clk = 1'b1; wt();
    end
    m_dio = 1'b0; wt();
    m_clk = 1'b0; wt();
    exp_fs++;
    if (in_frame && bits >= 1 && bits <= 7) exp_err++;
    in_frame = 1; first = 1; bits = 0;
  endtask

  task automatic bus_stop();
    m_dio = 1'b0; wt();
    m_clk = 1'b1; wt();
    m_dio = 1'b1; wt();
    if (in_frame) begin
      exp_fe++;
      if (bits >= 1 && bits <= 7) exp_err++;
    end
    in_frame = 0; bits = 0;
  endtask

  task automatic send_bits(input int n);
    for (int i = 0; i < n; i++) begin
      bus_bit(1'($urandom_range(0, 1)));
      bits++;
    end
  endtask

  // Full byte LSB-first plus the 9th (ACK) clock unless cut short in the ACK.
  task automatic send_byte(input logic [7:0] v, input bit stop_in_ack);
    for (int i = 0; i < 7; i++) bus_bit(v[i]);
    m_dio = v[7]; wt();
    m_clk = 1'b1; wt();
    chk("data_after_8th_rise[0]", dat[0], v);
    chk("data_after_8th_rise[1]", dat[1], v);
    chk("oe_before_8th_fall", oe[0], 1'b0);
    m_clk = 1'b0; wt();
    chk("oe_after_8th_fall", oe[0], 1'b1);
    exp_q.push_back({first, v});
    first = 0; last_data = v; bits = 0;
    if (stop_in_ack) return;
    m_dio = 1'b1; wt();
    m_clk = 1'b1; wt();
    chk("oe_9th_high", oe[0], 1'b1);
    chk("ack_on_wire", dio_w[0], 1'b0);
    m_clk = 1'b0; wt();
    chk("oe_after_9th_fall", oe[0], 1'b0);
  endtask

  task automatic check_events();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("frame_start_count[%0d]", k), n_fs[k], exp_fs);
      chk($sformatf("frame_end_count[%0d]", k), n_fe[k], exp_fe);
      chk($sformatf("frame_error_count[%0d]", k), n_err[k], exp_err);
      chk($sformatf("frame_error_unpaired[%0d]", k), n_err_alone[k], 0);
      chk($sformatf("data_hold[%0d]", k), dat[k], last_data);
    end
    chk("dv_count[0]", got0.size(), exp_q.size());
    chk("dv_count[1]", got1.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got0.size()) chk("first_and_byte[0]", got0[i], exp_q[i]);
      if (i < got1.size()) chk("first_and_byte[1]", got1[i], exp_q[i]);
    end
    got0.delete(); got1.delete(); exp_q.delete();
    chk("listen_only_oe_never", oe1_seen, 1'b0);
  endtask

  initial begin
    reset = 1'b0; m_clk = 1'b1; m_dio = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    for (int k = 0; k < 2; k++) begin
      chk("reset_oe", oe[k], 1'b0);
      chk("reset_data", dat[k], 8'h00);
      chk("reset_dv", dv[k], 1'b0);
      chk("reset_first", fb[k], 1'b0);
      chk("reset_fs", fs[k], 1'b0);
      chk("reset_fe", fe[k], 1'b0);
      chk("reset_ferr", ferr[k], 1'b0);
    end
    reset = 1'b1;
    wt(); wt();

    // Single byte with ACK.
    bus_start(); send_byte(8'h8F, 0); bus_stop(); check_events();

    // Three bytes in one frame.
    bus_start(); send_byte(8'hC0, 0); send_byte(8'h3F, 0); send_byte(8'h06, 0);
    bus_stop(); check_events();

    // Stop after 5 bits: error, partial byte dropped.
    bus_start(); send_bits(5); bus_stop(); check_events();

    // Repeated start after 3 bits, then a good byte.
    bus_start(); send_bits(3); bus_start(); send_byte(8'h44, 0); bus_stop();
    check_events();

    // Reset during the ACK of 8'h40.
    bus_start(); send_byte(8'h40, 1);
    #3 reset = 1'b0;
    #1 chk("oe_async_reset", oe[0], 1'b0);
    chk("data_async_reset", dat[0], 8'h00);
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    last_data = 8'h00; in_frame = 0; bits = 0;
    m_dio = 1'b1; wt();
    m_clk = 1'b1; wt();
    m_clk = 1'b0; wt();
    bus_stop(); send_bits(4); bus_stop();
    check_events();
    bus_start(); send_byte(8'h5A, 0); bus_stop(); check_events();

    // Listen-only instance on 8'hA5 followed by a second byte.
    bus_start(); send_byte(8'hA5, 0); send_byte(8'h3C, 0); bus_stop();
    check_events();

    // Random frames, some broken by a repeated start or an early stop.
    for (int f = 0; f < 6; f++) begin
      int nb;
      int mode;
      nb   = $urandom_range(1, 3);
      mode = $urandom_range(0, 2);
      bus_start();
      for (int b = 0; b < nb; b++) send_byte(8'($urandom_range(0, 255)), 0);
      if (mode != 0) send_bits($urandom_range(1, 6));
      if (mode == 2) begin
        bus_start();
        send_byte(8'($urandom_range(0, 255)), 0);
      end
      bus_stop();
      check_events();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tm1637_receiver.md
TM1637_RECEIVER -- requirements
Module: tm1637_receiver

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on bus_clk and bus_dio (legal range 2..4).
REQ-002 SHALL have parameter ACK_ENABLE, default 1, meaning ACK is driven on the 9th clock; 0 means listen-only.
REQ-003 SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port bus_clk  input  1  TM1637 CLK line, asynchronous to clk.
REQ-006 SHALL have port bus_dio  input  1  TM1637 DIO line as resolved on the wire, asynchronous to clk.
REQ-007 SHALL have port dio_oe  output  1  open-drain pull-low enable for DIO, where 1 drives DIO low.
REQ-008 SHALL have port data  output  8  last complete received byte.
REQ-009 SHALL have port data_valid  output  1  one-cycle pulse when data is updated.
REQ-010 SHALL have port first_byte  output  1  qualifies data_valid, meaning the byte is the first byte after a start.
REQ-011 SHALL have port frame_start  output  1  one-cycle pulse on a detected start condition.
REQ-012 SHALL have port frame_end  output  1  one-cycle pulse on a detected stop condition.
REQ-013 SHALL have port frame_error  output  1  one-cycle pulse when a start or stop occurs mid-byte (1 to 7 bits shifted).

Function
REQ-014 SHALL pass bus_clk and bus_dio through SYNC_STAGES flops, then one history flop; all edge and level decisions use only the synchronized signals (sclk, sdio).
REQ-015 SHALL detect a start when sdio falls and sclk is high in both the current and the previous sample.
REQ-016 SHALL detect a stop when sdio rises and sclk is high in both the current and the previous sample.
REQ-017 SHALL treat a cycle in which sclk and sdio change together as neither a start nor a stop.
REQ-018 SHALL implement an FSM with states IDLE, START, SHIFT, ACK and HOLD.
REQ-019 SHALL, from IDLE, move to START on start and pulse frame_start; bus activity without a start SHALL be ignored.
REQ-020 SHALL, from START, move to SHIFT on the sclk falling edge, clearing the bit counter (3 bits, 0..7).
REQ-021 SHALL, in SHIFT, on each sclk rising edge, shift sdio in LSB-first (bit n to data bit n) and increment the bit counter.
REQ-022 SHALL, on the 8th rising edge, load data and pulse data_valid in the next clk cycle (latency: 1 clk after the synchronized edge); first_byte SHALL equal 1 only for the first byte since the last start.
REQ-023 SHALL, after the 8th bit, enter ACK on the next sclk falling edge and assert dio_oe (only if ACK_ENABLE=1).
REQ-024 SHALL, in ACK, ignore the 9th sclk rising edge for data, deassert dio_oe on the following sclk falling edge, and move to SHIFT with the counter cleared.
REQ-025 SHALL disable start/stop detection while dio_oe=1 and for the first clk after it falls.
REQ-026 SHALL, on a stop in any non-IDLE state, pulse frame_end, deassert dio_oe and move to IDLE.
REQ-027 SHALL, on a start in any non-IDLE state, pulse frame_start, move to START and reset first_byte tracking.
REQ-028 SHALL pulse frame_error together with frame_start or frame_end when the bit counter is 1..7; the partial byte SHALL be discarded with no data_valid.
REQ-029 SHALL use HOLD only when ACK_ENABLE=0: after the 8th bit it skips the 9th clock (rising and falling edges), then returns to SHIFT.
REQ-030 SHALL hold data until the next complete byte; no other output SHALL depend combinationally on the bus inputs.

Reset
REQ-031 SHALL, while reset=0, set state IDLE, the shift register and data to 8'h00, dio_oe=0, all pulse outputs=0, first_byte=0, and the synchronizers to 1 (bus idle high).
REQ-032 SHALL, on reset release mid-transfer, wait for a new start; it SHALL NOT emit any data_valid for the interrupted byte.

Verification
REQ-033 SHALL be checked with: start, byte 8'h8F LSB-first, 9th clock, stop -> frame_start; data_valid with data=8'h8F and first_byte=1; dio_oe high exactly from the 8th to the 9th sclk fall; frame_end.
REQ-034 SHALL be checked with: start, 8'hC0, 8'h3F, 8'h06, stop -> three data_valid pulses; first_byte=1,0,0; data values in order.
REQ-035 SHALL be checked with: start, 5 bits, stop -> frame_end and frame_error in the same cycle; no data_valid; data unchanged.
REQ-036 SHALL be checked with: a repeated start after 3 bits, then 8'h44 -> frame_start and frame_error pulses; data_valid with data=8'h44 and first_byte=1.
REQ-037 SHALL be checked with: reset=0 asserted during the ACK of 8'h40 -> dio_oe=0 immediately (asynchronous); after release, no pulses until the next start.
REQ-038 SHALL be checked with: ACK_ENABLE=0 and 8'hA5 -> dio_oe stays 0 throughout; data_valid with data=8'hA5; the next byte is received correctly.
